// File: rtl/tremolo_scheduler.sv
// tremolo_scheduler
//   Triangle-LFO amplitude modulator for a stereo sample stream. Each accepted sample pair is
//   scaled by the gain latched at capture time. One signed multiplier is shared between the
//   channels: left first, then right. Both results are presented together with out_valid.
//
// Ports
//   CLK, RST_N       system clock (rising edge); asynchronous active-low reset
//   sample_valid     one-cycle input strobe; leftSampleIn/rightSampleIn valid with it
//   leftSampleIn     signed 16-bit left input
//   rightSampleIn    signed 16-bit right input
//   enable           1 = modulate, 0 = bypass (unity gain), sampled at capture
//   rate             LFO divider terminal count; one LFO step every rate+1 clocks
//   leftSampleOut    registered signed scaled left
//   rightSampleOut   registered signed scaled right
//   out_valid        one-cycle strobe, both outputs updated
//   busy             a pair is in flight
//   overrun          one-cycle pulse after a strobe was dropped while busy
//   gain_out         current LFO gain, unsigned, 2^SHIFT is unity
module tremolo_scheduler #(
  parameter int unsigned SHIFT  = 7,
  parameter int unsigned RATE_W = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              sample_valid,
  input  logic [15:0]       leftSampleIn,
  input  logic [15:0]       rightSampleIn,
  input  logic              enable,
  input  logic [RATE_W-1:0] rate,
  output logic [15:0]       leftSampleOut,
  output logic [15:0]       rightSampleOut,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun,
  output logic [SHIFT:0]    gain_out
);

  localparam int unsigned PW = 16 + SHIFT + 2;
  localparam logic [SHIFT:0] GainMax = {1'b1, {SHIFT{1'b0}}};
  localparam logic [SHIFT:0] GainMin = (SHIFT+1)'(1);

  typedef enum logic [1:0] {StIdle, StMulL, StMulR} state_e;

  state_e state_q, state_d;

  logic [RATE_W-1:0] div_cnt_q, div_cnt_d;
  logic              tick;
  logic [SHIFT:0]    gain_q, gain_d;
  logic              dir_up_q, dir_up_d;

  logic [15:0]       cap_l_q, cap_r_q, hold_l_q;
  logic [SHIFT:0]    cap_g_q;
  logic [15:0]       out_l_q, out_r_q;
  logic              out_valid_q, overrun_q;
  logic              accept;

  // LFO divider; a lowered rate below the current count fires at once.
  always_comb begin
    tick      = (div_cnt_q >= rate);
    div_cnt_d = tick ? '0 : div_cnt_q + RATE_W'(1);
  end

  // Triangle gain: bounces between 1 and 2^SHIFT, each extreme held for one tick.
  always_comb begin
    gain_d   = gain_q;
    dir_up_d = dir_up_q;
    if (tick) begin
      if (dir_up_q) begin
        if (gain_q < GainMax) begin
          gain_d = gain_q + GainMin;
        end else begin
          dir_up_d = 1'b0;
          gain_d   = gain_q - GainMin;
        end
      end else begin
        if (gain_q > GainMin) begin
          gain_d = gain_q - GainMin;
        end else begin
          dir_up_d = 1'b1;
          gain_d   = gain_q + GainMin;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q <= '0;
      gain_q    <= GainMin;
      dir_up_q  <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      gain_q    <= gain_d;
      dir_up_q  <= dir_up_d;
    end
  end

  // FSM: state register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sample_valid) state_d = StMulL;
      StMulL:  state_d = StMulR;
      StMulR:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    busy   = (state_q != StIdle);
    accept = (state_q == StIdle) && sample_valid;
  end

  // Shared multiplier; gain is zero-extended so it is always a positive signed operand.
  logic signed [15:0]      mul_a;
  logic signed [SHIFT+1:0] mul_b;
  logic signed [PW-1:0]    product;
  logic [15:0]             mul_res;
  logic                    unused_prod_bits;

  always_comb begin
    mul_a   = (state_q == StMulR) ? $signed(cap_r_q) : $signed(cap_l_q);
    mul_b   = $signed({1'b0, cap_g_q});
    product = PW'(mul_a) * PW'(mul_b);
    // Arithmetic shift right by SHIFT then truncate: floor division, fits for gain <= 2^SHIFT.
    mul_res = product[SHIFT +: 16];
  end

  assign unused_prod_bits = ^{product[PW-1:SHIFT+16], product[SHIFT-1:0]};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cap_l_q     <= '0;
      cap_r_q     <= '0;
      cap_g_q     <= GainMax;
      hold_l_q    <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q   <= sample_valid && (state_q != StIdle);
      out_valid_q <= (state_q == StMulR);
      if (accept) begin
        cap_l_q <= leftSampleIn;
        cap_r_q <= rightSampleIn;
        // Snapshot takes the pre-update gain even when a tick lands on this edge.
        cap_g_q <= enable ? gain_q : GainMax;
      end
      if (state_q == StMulL) begin
        hold_l_q <= mul_res;
      end
      if (state_q == StMulR) begin
        out_l_q <= hold_l_q;
        out_r_q <= mul_res;
      end
    end
  end

  assign leftSampleOut  = out_l_q;
  assign rightSampleOut = out_r_q;
  assign out_valid      = out_valid_q;
  assign overrun        = overrun_q;
  assign gain_out       = gain_q;

endmodule

// File: tb/tb_tremolo_scheduler.sv
module tb_tremolo_scheduler;

  localparam int SHIFT  = 7;
  localparam int RATE_W = 16;
  localparam int PEAK   = 1 << SHIFT;
  localparam int PERIOD = 2 * PEAK - 2;

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              sample_valid;
  logic [15:0]       l_in, r_in;
  logic              enable;
  logic [RATE_W-1:0] rate;
  logic [15:0]       leftSampleOut, rightSampleOut;
  logic              out_valid, busy, overrun;
  logic [SHIFT:0]    gain_out;

  tremolo_scheduler #(.SHIFT(SHIFT), .RATE_W(RATE_W)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .sample_valid  (sample_valid),
    .leftSampleIn  (l_in),
    .rightSampleIn (r_in),
    .enable        (enable),
    .rate          (rate),
    .leftSampleOut (leftSampleOut),
    .rightSampleOut(rightSampleOut),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun),
    .gain_out      (gain_out)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Gain after k LFO steps from reset: closed-form triangle.
  function automatic int tri_gain(input int k);
    int p;
    p = k % PERIOD;
    return (p <= PEAK - 1) ? p + 1 : 2 * PEAK - 1 - p;
  endfunction

  // floor(s * g / 2^SHIFT), kept to 16 bits.
  function automatic logic [15:0] scale(input logic [15:0] s, input int g);
    int p, q;
    p = int'($signed(s)) * g;
    q = p / PEAK;
    if (p < 0 && q * PEAK != p) q = q - 1;
    return q[15:0];
  endfunction

  // Reference model; every m_* value is what the DUT must show in the next cycle.
  int          m_cnt, m_ticks, m_free, m_due, m_gain;
  bit          m_pend, m_ov, m_busy, m_ovr;
  logic [15:0] m_pl, m_pr, m_l, m_r;

  always @(posedge CLK or negedge RST_N) begin : model_p
    int g;
    bit acc, tk, deliver;
    int free_new;
    if (!RST_N) begin
      m_cnt <= 0; m_ticks <= 0; m_free <= 0; m_due <= 0; m_pend <= 1'b0;
      m_l <= '0; m_r <= '0; m_ov <= 1'b0; m_busy <= 1'b0; m_ovr <= 1'b0; m_gain <= 1;
    end else begin
      acc     = sample_valid && (cyc >= m_free);
      g       = enable ? tri_gain(m_ticks) : PEAK;
      deliver = m_pend && (m_due == cyc + 1);
      m_ov <= deliver;
      if (deliver) begin
        m_l <= m_pl;
        m_r <= m_pr;
      end
      if (acc) begin
        m_pend <= 1'b1;
        m_due  <= cyc + 3;
        m_free <= cyc + 3;
        m_pl   <= scale(l_in, g);
        m_pr   <= scale(r_in, g);
      end else if (deliver) begin
        m_pend <= 1'b0;
      end
      free_new = acc ? cyc + 3 : m_free;
      m_busy  <= (cyc + 1 < free_new);
      m_ovr   <= sample_valid && !acc;
      tk       = (m_cnt >= int'(rate));
      m_cnt   <= tk ? 0 : m_cnt + 1;
      m_ticks <= m_ticks + int'(tk);
      m_gain  <= tri_gain(m_ticks + int'(tk));
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cycle();
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("left_out", {16'b0, leftSampleOut}, {16'b0, m_l});
    chk("right_out", {16'b0, rightSampleOut}, {16'b0, m_r});
    chk("gain_out", {{(31-SHIFT){1'b0}}, gain_out}, m_gain);
  endtask

  // Entered and left at posedge+1; checks at the falling edge.
  task automatic cycle();
    @(negedge CLK);
    check_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic strobe(input logic [15:0] l, input logic [15:0] r);
    sample_valid = 1'b1;
    l_in = l;
    r_in = r;
    cycle();
    sample_valid = 1'b0;
  endtask

  task automatic apply_reset();
    RST_N = 1'b0;
    cycle();
    RST_N = 1'b1;
  endtask

  initial begin
    RST_N = 1'b0; sample_valid = 1'b0; l_in = '0; r_in = '0; enable = 1'b0; rate = '0;
    @(posedge CLK);
    #1;
    idle(2);
    RST_N = 1'b1;
    idle(10);

    // Bypass is bit-exact, including the most negative value.
    enable = 1'b0;
    strobe(16'sd32767, -16'sd32768);
    idle(2);
    strobe(-16'sd1, 16'sd1);
    idle(2);
    strobe(16'h1234, -16'sd5);
    idle(2);
    chk("bypass_l", {16'b0, leftSampleOut}, 32'h1234);
    chk("bypass_r", {16'b0, rightSampleOut}, 32'hfffb);
    idle(1);

    // Asynchronous reset mid-cycle clears the outputs at once.
    #3 RST_N = 1'b0;
    #1;
    chk("arst_left", {16'b0, leftSampleOut}, 32'h0);
    chk("arst_right", {16'b0, rightSampleOut}, 32'h0);
    chk("arst_gain", {{(31-SHIFT){1'b0}}, gain_out}, 32'd1);
    chk("arst_valid", 32'(out_valid), 32'd0);
    cycle();
    RST_N = 1'b1;

    // Gain 1 straight after reset: -32768 scales to -256.
    enable = 1'b1;
    strobe(-16'sd32768, 16'sd1000);
    idle(2);
    chk("gain1_l", {16'b0, leftSampleOut}, 32'h0000ff00);
    chk("gain1_r", {16'b0, rightSampleOut}, 32'd7);
    idle(1);

    // Triangle sweep at rate 0.
    rate = '0;
    idle(300);

    // Gain 64 with rate 3: 1000 -> 500, -1001 -> -501.
    rate = 16'd3;
    apply_reset();
    for (int i = 0; i < 400 && gain_out != 64; i++) cycle();
    chk("reach_gain64", {{(31-SHIFT){1'b0}}, gain_out}, 32'd64);
    strobe(16'sd1000, -16'sd1001);
    idle(2);
    chk("g64_l", {16'b0, leftSampleOut}, 32'd500);
    chk("g64_r", {16'b0, rightSampleOut}, 32'h0000fe0b);
    idle(1);

    // Overrun: strobes at N, N+1, accepted again at N+3.
    strobe(16'sd300, -16'sd300);
    strobe(16'sd7, 16'sd9);
    idle(1);
    strobe(-16'sd12345, 16'sd2222);
    idle(4);

    // Reset one cycle into a pair: no out_valid afterwards.
    strobe(16'sd100, 16'sd200);
    RST_N = 1'b0;
    cycle();
    RST_N = 1'b1;
    idle(5);

    // Rate drop below the running count.
    rate = 16'd1000;
    apply_reset();
    idle(100);
    rate = 16'd10;
    idle(30);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      sample_valid = 1'($urandom_range(0, 1));
      l_in = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
      r_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) enable = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 63) == 0) rate = 16'($urandom_range(0, 4));
      cycle();
    end
    sample_valid = 1'b0;
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
